// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microcoded sequencer: stage names, microword
// field layout and the sequencer FSM state type.
package micro_seq_pkg;

   localparam logic [2:0] STG_IF  = 3'd0;
   localparam logic [2:0] STG_ID  = 3'd1;
   localparam logic [2:0] STG_EX  = 3'd2;
   localparam logic [2:0] STG_MEM = 3'd3;
   localparam logic [2:0] STG_WB  = 3'd4;

   // Microword layout, LSB first: wait, last, nxt[SWIDTH], ctrl[CWIDTH], valid
   localparam int unsigned MW_WAIT    = 0;
   localparam int unsigned MW_LAST    = 1;
   localparam int unsigned MW_NXT_LSB = 2;
   localparam int unsigned MW_EXTRA   = 3;

   function automatic int unsigned mw_ctrl_lsb(input int unsigned swidth);
      return MW_NXT_LSB + swidth;
   endfunction

   typedef enum logic {
      S_IDLE,
      S_RUN
   } seq_state_t;

endpackage

// File: rtl/micro_store.sv
// Writable microcode store: asynchronous read, synchronous write, and a
// per-entry valid vector cleared by reset (data array itself is not reset).
module micro_store
   import micro_seq_pkg::*;
#(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 31
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_wvalid,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata,
   output logic          o_rvalid
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_valid <= '0;
      else if (i_we) r_valid[i_waddr] <= i_wvalid;
   end

   assign o_rdata  = r_mem[i_raddr];
   assign o_rvalid = r_valid[i_raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Programmable microcoded control unit: walks per-class microcode, handling
// stage jumps, memory-wait stalls, back-to-back issue and illegal entries.
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int unsigned CWIDTH = 26,
   parameter int unsigned OPW    = 5,
   parameter int unsigned SWIDTH = 3
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      inst_valid,
   input  logic [OPW-1:0]            inst_class,
   input  logic                      mem_ready,
   input  logic                      prog_we,
   input  logic [OPW+SWIDTH-1:0]     prog_addr,
   input  logic [CWIDTH+SWIDTH+2:0]  prog_data,
   output logic                      inst_ready,
   output logic [CWIDTH-1:0]         control_signal,
   output logic [SWIDTH-1:0]         stage,
   output logic                      busy,
   output logic                      inst_done,
   output logic                      illegal
);

   localparam int unsigned MWIDTH = CWIDTH + SWIDTH + MW_EXTRA;
   localparam int unsigned CLSB   = mw_ctrl_lsb(SWIDTH);

   seq_state_t          r_state, w_state_nxt;
   logic [OPW-1:0]      r_op, w_op_nxt;
   logic [SWIDTH-1:0]   r_stage, w_stage_nxt;
   logic                r_illegal, w_set_illegal;

   logic [OPW+SWIDTH-1:0] w_raddr;
   logic [MWIDTH-2:0]     w_word;
   logic                  w_vld;
   logic                  w_wait, w_last;
   logic [SWIDTH-1:0]     w_nxt;
   logic [CWIDTH-1:0]     w_ctrl;

   assign w_raddr = {r_op, r_stage};

   micro_store #(
      .AW (OPW + SWIDTH),
      .DW (MWIDTH - 1)
   ) u_store (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_we     (prog_we),
      .i_waddr  (prog_addr),
      .i_wdata  (prog_data[MWIDTH-2:0]),
      .i_wvalid (prog_data[MWIDTH-1]),
      .i_raddr  (w_raddr),
      .o_rdata  (w_word),
      .o_rvalid (w_vld)
   );

   assign w_wait = w_word[MW_WAIT];
   assign w_last = w_word[MW_LAST];
   assign w_nxt  = w_word[MW_NXT_LSB +: SWIDTH];
   assign w_ctrl = w_word[CLSB +: CWIDTH];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_stage   <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_stage <= w_stage_nxt;
         if (w_set_illegal) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_op_nxt       = r_op;
      w_stage_nxt    = r_stage;
      w_set_illegal  = 1'b0;
      control_signal = '0;
      inst_done      = 1'b0;
      inst_ready     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            inst_ready = 1'b1;
            if (inst_valid) begin
               w_op_nxt    = inst_class;
               w_stage_nxt = '0;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!w_vld) begin
               w_set_illegal = 1'b1;
               w_state_nxt   = S_IDLE;
            end else begin
               control_signal = w_ctrl;
               // Stall has priority over completion so a waiting last stage holds.
               if (w_wait && !mem_ready) begin
                  w_stage_nxt = r_stage;
               end else if (w_last) begin
                  inst_done  = 1'b1;
                  inst_ready = 1'b1;
                  if (inst_valid) begin
                     w_op_nxt    = inst_class;
                     w_stage_nxt = '0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_stage_nxt = w_nxt;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign stage   = r_stage;
   assign busy    = (r_state == S_RUN);
   assign illegal = r_illegal;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed microcode programs push expected
// per-cycle RUN outputs; a negedge monitor pops and compares while busy.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_valid = 1'b0;
   logic [4:0]  inst_class = '0;
   logic        mem_ready = 1'b1;
   logic        prog_we = 1'b0;
   logic [7:0]  prog_addr = '0;
   logic [31:0] prog_data = '0;
   logic        inst_ready;
   logic [25:0] control_signal;
   logic [2:0]  stage;
   logic        busy;
   logic        inst_done;
   logic        illegal;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0]  stg;
      logic [25:0] ctl;
      logic        done;
      logic        rdy;
   } exp_t;

   exp_t sb[$];

   micro_sequencer #(.CWIDTH(26), .OPW(5), .SWIDTH(3)) dut (
      .CLK            (clk),
      .RST            (rst),
      .inst_valid     (inst_valid),
      .inst_class     (inst_class),
      .mem_ready      (mem_ready),
      .prog_we        (prog_we),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .inst_ready     (inst_ready),
      .control_signal (control_signal),
      .stage          (stage),
      .busy           (busy),
      .inst_done      (inst_done),
      .illegal        (illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mw(input logic v, input logic [25:0] c,
                                      input logic [2:0] n, input logic l, input logic w);
      return {v, c, n, l, w};
   endfunction

   task automatic push(input logic [2:0] s, input logic [25:0] c, input logic d, input logic r);
      exp_t e;
      e.stg = s; e.ctl = c; e.done = d; e.rdy = r;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (busy) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL seq_unexpected: got stage=%0d ctrl=%0h with no expected entry", stage, control_signal);
         end else begin
            e = sb.pop_front();
            if (stage !== e.stg || control_signal !== e.ctl || inst_done !== e.done || inst_ready !== e.rdy) begin
               failures++;
               $display("FAIL seq: got stage=%0d ctrl=%0h done=%0b rdy=%0b expected stage=%0d ctrl=%0h done=%0b rdy=%0b",
                        stage, control_signal, inst_done, inst_ready, e.stg, e.ctl, e.done, e.rdy);
            end
         end
      end
   end

   task automatic prog(input logic [4:0] cls, input logic [2:0] stg, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = {cls, stg}; prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic issue(input logic [4:0] cls);
      inst_valid = 1'b1; inst_class = cls;
      @(posedge clk); #1;
      inst_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic prog_class0();
      prog(5'd0, 3'd0, mw(1'b1, 26'h1, 3'd1, 1'b0, 1'b0));
      prog(5'd0, 3'd1, mw(1'b1, 26'h2, 3'd2, 1'b0, 1'b0));
      prog(5'd0, 3'd2, mw(1'b1, 26'h4, 3'd4, 1'b0, 1'b0));
      prog(5'd0, 3'd4, mw(1'b1, 26'h8, 3'd0, 1'b1, 1'b0));
   endtask

   initial begin
      #3;
      chk("rst_ctrl",  {6'd0, control_signal}, 32'd0);
      chk("rst_stage", {29'd0, stage}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_done",  {31'd0, inst_done}, 32'd0);
      chk("rst_ready", {31'd0, inst_ready}, 32'd1);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Unprogrammed class: one RUN cycle then illegal
      push(3'd0, 26'h0, 1'b0, 1'b0);
      issue(5'd0);
      @(posedge clk); #1;
      chk("illegal_set", {31'd0, illegal}, 32'd1);
      chk("illegal_idle", {31'd0, busy}, 32'd0);
      chk("illegal_ctrl", {6'd0, control_signal}, 32'd0);
      chk("illegal_ready", {31'd0, inst_ready}, 32'd1);

      // IF->ID->EX->WB skipping MEM
      prog_class0();
      push(3'd0, 26'h1, 1'b0, 1'b0);
      push(3'd1, 26'h2, 1'b0, 1'b0);
      push(3'd2, 26'h4, 1'b0, 1'b0);
      push(3'd4, 26'h8, 1'b1, 1'b1);
      issue(5'd0);
      wait_idle();

      // Load with memory wait at stage 3
      prog(5'b10100, 3'd0, mw(1'b1, 26'h10, 3'd3, 1'b0, 1'b0));
      prog(5'b10100, 3'd3, mw(1'b1, 26'h20, 3'd4, 1'b0, 1'b1));
      prog(5'b10100, 3'd4, mw(1'b1, 26'h40, 3'd0, 1'b1, 1'b0));
      mem_ready = 1'b0;
      push(3'd0, 26'h10, 1'b0, 1'b0);
      repeat (4) push(3'd3, 26'h20, 1'b0, 1'b0);
      push(3'd4, 26'h40, 1'b1, 1'b1);
      issue(5'b10100);
      repeat (4) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
      wait_idle();

      // Back-to-back issue of class 0 then class 1
      prog(5'd1, 3'd0, mw(1'b1, 26'h100, 3'd2, 1'b0, 1'b0));
      prog(5'd1, 3'd2, mw(1'b1, 26'h200, 3'd0, 1'b1, 1'b0));
      push(3'd0, 26'h1, 1'b0, 1'b0);
      push(3'd1, 26'h2, 1'b0, 1'b0);
      push(3'd2, 26'h4, 1'b0, 1'b0);
      push(3'd4, 26'h8, 1'b1, 1'b1);
      push(3'd0, 26'h100, 1'b0, 1'b0);
      push(3'd2, 26'h200, 1'b1, 1'b1);
      inst_valid = 1'b1; inst_class = 5'd0;
      @(posedge clk); #1;
      inst_class = 5'd1;
      repeat (4) begin @(posedge clk); #1; end
      inst_valid = 1'b0;
      chk("b2b_no_gap", {31'd0, busy}, 32'd1);
      chk("b2b_ctrl", {6'd0, control_signal}, 32'h100);
      wait_idle();

      // Asynchronous reset during stage 2
      push(3'd0, 26'h1, 1'b0, 1'b0);
      push(3'd1, 26'h2, 1'b0, 1'b0);
      issue(5'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_stage", {29'd0, stage}, 32'd2);
      rst = 1'b1;
      #1;
      chk("arst_ctrl",  {6'd0, control_signal}, 32'd0);
      chk("arst_stage", {29'd0, stage}, 32'd0);
      chk("arst_busy",  {31'd0, busy}, 32'd0);
      chk("arst_done",  {31'd0, inst_done}, 32'd0);
      chk("arst_ready", {31'd0, inst_ready}, 32'd1);
      chk("arst_illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      push(3'd0, 26'h0, 1'b0, 1'b0);
      issue(5'd0);
      @(posedge clk); #1;
      chk("reissue_illegal", {31'd0, illegal}, 32'd1);

      // Rewrite entry {0,2} while class 0 sits at stage 1
      prog_class0();
      push(3'd0, 26'h1, 1'b0, 1'b0);
      push(3'd1, 26'h2, 1'b0, 1'b0);
      push(3'd2, 26'h3FFFFFF, 1'b0, 1'b0);
      push(3'd4, 26'h8, 1'b1, 1'b1);
      issue(5'd0);
      @(posedge clk); #1;
      prog(5'd0, 3'd2, mw(1'b1, 26'h3FFFFFF, 3'd4, 1'b0, 1'b0));
      wait_idle();

      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
